can_tx_stuff_sequencer: RTL
===========================

Name: can_tx_stuff_sequencer

Overview:
- Transmit-side bit sequencer for the CAN controller.
- Accepts a pre-assembled stuffable frame segment (SOF through last CRC bit) and serialises it MSB-first, one bit per bit-time strobe.
- Inserts stuff bits itself in the stuffable region, then appends the fixed unstuffed tail (CRC delimiter, ACK slot, ACK delimiter, 7-bit EOF) and 3-bit intermission.
- Sits between the frame assembler and the bit-timing/PHY stage; owns the decision of when stuffing is active.

Parameters:
- MAX_BITS, 128, capacity of frame_bits in bits (maximum stuffable segment length).
- LEN_W, $clog2(MAX_BITS+1), width of frame_len.
- CNT_W, 8, width of the stuff_count statistic.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- bit_tick  input  1  one-clk strobe per CAN bit time; all bus-visible changes happen only on clocks where bit_tick=1.
- frame_valid  input  1  frame descriptor valid.
- frame_ready  output  1  sequencer can accept a descriptor.
- frame_bits  input  MAX_BITS  stuffable segment; first bit to send (SOF) at index MAX_BITS-1.
- frame_len  input  LEN_W  number of valid bits in frame_bits, counted from MSB.
- arb_lost  input  1  arbitration lost; abort the current frame.
- rx_bit  input  1  sampled bus level; used only with the optional feature.
- tx_bit  output  1  bit driven to the bus; 0 = dominant, 1 = recessive.
- stuff_bit  output  1  high while tx_bit is a stuff bit.
- busy  output  1  state != IDLE.
- done  output  1  one-clk pulse when intermission completes.
- aborted  output  1  one-clk pulse on an abort.
- len_err  output  1  one-clk pulse on an illegal frame_len.
- bit_err  output  1  one-clk pulse on a bit-monitor mismatch (optional feature).
- stuff_count  output  CNT_W  stuff bits inserted in the current or last frame; saturates at all-ones.

Behaviour:
Reset values:
- tx_bit=1, stuff_bit=0, busy=0, done=0, aborted=0, len_err=0, bit_err=0, stuff_count=0.
- state=IDLE, run_cnt=0.

States: IDLE, STUFF, TAIL, IFS.

IDLE:
- frame_ready = (state==IDLE), combinational.
- Handshake: acceptance when frame_valid && frame_ready, independent of bit_tick.
- On acceptance with 1 <= frame_len <= MAX_BITS:
  - load shift register and remaining count;
  - clear stuff_count, run_cnt=0;
  - go to STUFF.
  - tx_bit stays 1 until the next bit_tick.
- On acceptance with frame_len=0 or frame_len>MAX_BITS:
  - descriptor is consumed;
  - len_err pulses for one clk;
  - state stays IDLE.

STUFF (stuffing active), evaluated on each bit_tick:
- If run_cnt==5:
  - drive tx_bit=~last_bit, stuff_bit=1;
  - last_bit=~last_bit, run_cnt=1;
  - stuff_count+1 (saturating).
- Else if remaining>0:
  - drive the shift register MSB, shift left, remaining-1;
  - run_cnt = (bit==last_bit) ? run_cnt+1 : 1; last_bit=bit;
  - stuff_bit=0.
  - run_cnt=0 at frame start, so SOF always starts a run of 1.
- Else (remaining==0 and run_cnt!=5):
  - go to TAIL and drive the first tail bit on this same tick.
- Stuff bits count toward the next run.
- A run of 5 ending on the last CRC bit still gets its stuff bit before the CRC delimiter.

TAIL:
- 10 recessive bits (tx_bit=1, stuff_bit=0), one per bit_tick; no stuffing.
- After the 10th, go to IFS.

IFS:
- 3 recessive bit times.
- On the bit_tick ending the 3rd: go to IDLE, done=1 for one clk.
- frame_ready rises in the following clk.

Abort:
- arb_lost=1 on any clk while in STUFF: go to IDLE immediately (no bit_tick needed).
- tx_bit=1, stuff_bit=0, aborted pulses for one clk, no done.
- arb_lost is ignored outside STUFF.

Other rules:
- bit_tick while IDLE: tx_bit held at 1.
- frame_valid while busy: ignored; frame_ready=0.
- Reset mid-frame: all outputs return immediately to their reset values.

Optional Feature:
CAN_TX_BITMON_EN
- Defined:
  - On each bit_tick in STUFF, except the tick that drives SOF, compare rx_bit with the tx_bit currently on the bus.
  - On mismatch with arb_lost=0: bit_err pulses for one clk and the sequencer aborts as above, without pulsing aborted.
  - arb_lost has priority over a mismatch.
- Not defined:
  - rx_bit is ignored; bit_err is tied to 0.

Test Plan:
- Zero run: len=8, bits=0000_0000, rx_bit follows tx_bit → tx sequence 0,0,0,0,0,1(stuff_bit=1),0,0,0; then 13 ones; done after 22 ticks; stuff_count=1.
- Stuff bit counts toward the next run: len=8, bits=1111_1000 → 1,1,1,1,1,0(stuff),0,0,0; no second stuff; stuff_count=1.
- End-of-segment stuff: len=5, bits=00000 → 0,0,0,0,0,1(stuff); then 10 TAIL ones, 3 IFS ones; done on tick 19.
- Abort: arb_lost asserted after the 3rd bit of len=20 → same clk: tx_bit=1, aborted=1, busy=0; next descriptor accepted; stuff_count restarts at 0.
- Illegal length: frame_len=0, then frame_len=MAX_BITS+1 → len_err pulses each time; tx_bit stays 1, busy=0.
- CAN_TX_BITMON_EN: force rx_bit=0 while tx_bit=1 on bit 4 → bit_err=1, state IDLE, done never pulses; without the macro, same stimulus completes normally.

Source files
------------

// File: rtl/can_tx_stuff_sequencer.sv
// can_tx_stuff_sequencer: serialises a CAN stuffable segment with bit stuffing, then the fixed tail and intermission.
// Optional bus bit monitor enabled by defining CAN_TX_BITMON_EN.
module can_tx_stuff_sequencer #(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = $clog2(MAX_BITS + 1),
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bit_tick,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [MAX_BITS-1:0] frame_bits,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic                arb_lost,
    input  logic                rx_bit,
    output logic                tx_bit,
    output logic                stuff_bit,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                len_err,
    output logic                bit_err,
    output logic [CNT_W-1:0]    stuff_count
);
    typedef enum logic [1:0] {IDLE, STUFF, TAIL, IFS} state_t;

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [2:0]          run_q, run_d;
    logic                last_q, last_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                tx_q, tx_d, stuff_q, stuff_d;
    logic                done_q, done_d, abort_q, abort_d;
    logic                len_err_q, len_err_d, bit_err_q, bit_err_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic                mon_err;

`ifdef CAN_TX_BITMON_EN
    // run_q==0 only before SOF has been driven, so the SOF tick is skipped
    assign mon_err = bit_tick && (run_q != 3'd0) && (rx_bit != tx_q);
`else
    logic unused_rx;
    assign unused_rx = rx_bit;
    assign mon_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rem_d     = rem_q;
        run_d     = run_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        stuff_d   = stuff_q;
        scnt_d    = scnt_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        len_err_d = 1'b0;
        bit_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                stuff_d = 1'b0;
                if (frame_valid) begin
                    if (frame_len == '0 || frame_len > LEN_W'(MAX_BITS)) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d = STUFF;
                        sr_d    = frame_bits;
                        rem_d   = frame_len;
                        run_d   = 3'd0;
                        scnt_d  = '0;
                    end
                end
            end
            STUFF: begin
                if (arb_lost || mon_err) begin
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    stuff_d   = 1'b0;
                    abort_d   = arb_lost;
                    bit_err_d = !arb_lost;
                end else if (bit_tick) begin
                    if (run_q == 3'd5) begin
                        tx_d    = ~last_q;
                        stuff_d = 1'b1;
                        last_d  = ~last_q;
                        run_d   = 3'd1;
                        scnt_d  = &scnt_q ? scnt_q : scnt_q + 1'b1;
                    end else if (rem_q != '0) begin
                        tx_d    = sr_q[MAX_BITS-1];
                        stuff_d = 1'b0;
                        sr_d    = {sr_q[MAX_BITS-2:0], 1'b0};
                        rem_d   = rem_q - 1'b1;
                        run_d   = (sr_q[MAX_BITS-1] == last_q) ? run_q + 3'd1 : 3'd1;
                        last_d  = sr_q[MAX_BITS-1];
                    end else begin
                        state_d = TAIL;
                        tx_d    = 1'b1;
                        stuff_d = 1'b0;
                        cnt_d   = 4'd1;
                    end
                end
            end
            TAIL: begin
                if (bit_tick) begin
                    state_d = (cnt_q == 4'd10) ? IFS : TAIL;
                    cnt_d   = (cnt_q == 4'd10) ? 4'd1 : cnt_q + 4'd1;
                end
            end
            IFS: begin
                if (bit_tick) begin
                    state_d = (cnt_q == 4'd2) ? IDLE : IFS;
                    done_d  = (cnt_q == 4'd2);
                    cnt_d   = cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            rem_q     <= '0;
            run_q     <= 3'd0;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            tx_q      <= 1'b1;
            stuff_q   <= 1'b0;
            scnt_q    <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            len_err_q <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rem_q     <= rem_d;
            run_q     <= run_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            stuff_q   <= stuff_d;
            scnt_q    <= scnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            len_err_q <= len_err_d;
            bit_err_q <= bit_err_d;
        end
    end

    assign frame_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tx_bit      = tx_q;
    assign stuff_bit   = stuff_q;
    assign done        = done_q;
    assign aborted     = abort_q;
    assign len_err     = len_err_q;
    assign bit_err     = bit_err_q;
    assign stuff_count = scnt_q;
endmodule
